// File: rtl/ddr_out_serializer.sv
// Serializes parallel words two bits per clock onto a DDR output pair (dr/df),
// with a one-word skid buffer for gapless streaming and a programmable oe tail.
module ddr_out_serializer #(
  parameter int   WIDTH    = 8,
  parameter int   OE_HOLD  = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             CLK,
  input  logic             ALn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dr,
  output logic             df,
  output logic             oe,
  output logic             busy
);

  localparam int BEATS = WIDTH / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW    = (OE_HOLD > 0) ? $clog2(OE_HOLD + 1) : 1;
  localparam logic [CW-1:0] LAST     = CW'(BEATS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(OE_HOLD);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full_q;
  logic [CW-1:0]    cnt_q;
  logic [HW-1:0]    hcnt_q;
  logic             dr_q;
  logic             df_q;
  logic             oe_q;

  logic             accept;
  logic             cnt_last;
  logic             load;
  logic [WIDTH-1:0] load_src;

  assign accept   = in_valid & ~buf_full_q;
  assign cnt_last = (cnt_q == LAST);

  // A fresh word starts whenever the shifter is free; the buffered word wins over a new one.
  assign load = (state_q == IDLE  && accept) ||
                (state_q == HOLD  && accept) ||
                (state_q == SHIFT && cnt_last && (buf_full_q || accept));
  assign load_src = buf_full_q ? buf_q : in_data;

  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      dr_q       <= IDLE_VAL;
      df_q       <= IDLE_VAL;
      oe_q       <= 1'b0;
    end else if (load) begin
      dr_q       <= load_src[0];
      df_q       <= load_src[1];
      sr_q       <= load_src >> 2;
      cnt_q      <= '0;
      oe_q       <= 1'b1;
      buf_full_q <= 1'b0;
      state_q    <= SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          if (!cnt_last) begin
            dr_q  <= sr_q[0];
            df_q  <= sr_q[1];
            sr_q  <= sr_q >> 2;
            cnt_q <= cnt_q + 1'b1;
            oe_q  <= 1'b1;
            if (accept) begin
              buf_q      <= in_data;
              buf_full_q <= 1'b1;
            end
          end else if (OE_HOLD > 0) begin
            dr_q    <= IDLE_VAL;
            df_q    <= IDLE_VAL;
            oe_q    <= 1'b1;
            hcnt_q  <= HW'(1);
            state_q <= HOLD;
          end else begin
            dr_q    <= IDLE_VAL;
            df_q    <= IDLE_VAL;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          dr_q <= IDLE_VAL;
          df_q <= IDLE_VAL;
          if (hcnt_q == HOLD_MAX) begin
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
            oe_q   <= 1'b1;
          end
        end
        default: begin
          dr_q    <= IDLE_VAL;
          df_q    <= IDLE_VAL;
          oe_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = ~buf_full_q;
  assign busy     = (state_q != IDLE) | buf_full_q;
  assign dr       = dr_q;
  assign df       = df_q;
  assign oe       = oe_q;

endmodule

// File: tb/tb_ddr_out_serializer.sv
// Bench for ddr_out_serializer: WIDTH=8/OE_HOLD=2 and WIDTH=2/OE_HOLD=0 instances
// against a beat-queue reference model, plus directed cases with literal expectations.
module tb_ddr_out_serializer;

  logic       CLK = 1'b0;
  logic       ALn = 1'b0;

  logic [7:0] in_data8 = '0;
  logic       in_valid8 = 1'b0;
  logic       in_ready8, dr8, df8, oe8, busy8;

  logic [1:0] in_data2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, dr2, df2, oe2, busy2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: every accepted word becomes WIDTH/2 beats in a queue,
  // one beat leaves per clock; an idle counter models the oe tail.
  int q8[$];
  int q2[$];
  int idle8 = 2;
  int idle2 = 0;
  logic m_dr8, m_df8, m_oe8;
  logic m_dr2, m_df2, m_oe2;
  logic last_acc8;

  ddr_out_serializer #(.WIDTH(8), .OE_HOLD(2), .IDLE_VAL(1'b0)) dut8 (
    .CLK(CLK), .ALn(ALn), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .dr(dr8), .df(df8), .oe(oe8), .busy(busy8)
  );

  ddr_out_serializer #(.WIDTH(2), .OE_HOLD(0), .IDLE_VAL(1'b0)) dut2 (
    .CLK(CLK), .ALn(ALn), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .dr(dr2), .df(df2), .oe(oe2), .busy(busy2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    q8.delete();
    q2.delete();
    idle8 = 2;
    idle2 = 0;
    m_dr8 = 1'b0; m_df8 = 1'b0; m_oe8 = 1'b0;
    m_dr2 = 1'b0; m_df2 = 1'b0; m_oe2 = 1'b0;
    last_acc8 = 1'b0;
  endtask

  task automatic check_all();
    chk("w8_dr",    {1'b0, dr8},       {1'b0, m_dr8});
    chk("w8_df",    {1'b0, df8},       {1'b0, m_df8});
    chk("w8_oe",    {1'b0, oe8},       {1'b0, m_oe8});
    chk("w8_ready", {1'b0, in_ready8}, {1'b0, (q8.size() <= 3)});
    chk("w8_busy",  {1'b0, busy8},     {1'b0, m_oe8});
    chk("w2_dr",    {1'b0, dr2},       {1'b0, m_dr2});
    chk("w2_df",    {1'b0, df2},       {1'b0, m_df2});
    chk("w2_oe",    {1'b0, oe2},       {1'b0, m_oe2});
    chk("w2_ready", {1'b0, in_ready2}, {1'b0, (q2.size() == 0)});
    chk("w2_busy",  {1'b0, busy2},     {1'b0, m_oe2});
  endtask

  // One clock: drive inputs, advance the model across the edge, compare 1 ns later.
  task automatic step(input logic v8, input logic [7:0] d8,
                      input logic v2, input logic [1:0] d2);
    logic acc8, acc2;
    int   b;
    in_valid8 = v8; in_data8 = d8;
    in_valid2 = v2; in_data2 = d2;
    acc8 = v8 && (q8.size() <= 3);
    acc2 = v2 && (q2.size() == 0);
    @(posedge CLK);
    if (acc8) for (int k = 0; k < 4; k++) q8.push_back(int'({d8[2*k+1], d8[2*k]}));
    if (acc2) q2.push_back(int'({d2[1], d2[0]}));
    if (q8.size() > 0) begin
      b = q8.pop_front();
      m_dr8 = b[0]; m_df8 = b[1]; m_oe8 = 1'b1; idle8 = 0;
    end else begin
      m_dr8 = 1'b0; m_df8 = 1'b0;
      if (idle8 < 2) begin idle8++; m_oe8 = 1'b1; end
      else m_oe8 = 1'b0;
    end
    if (q2.size() > 0) begin
      b = q2.pop_front();
      m_dr2 = b[0]; m_df2 = b[1]; m_oe2 = 1'b1; idle2 = 0;
    end else begin
      m_dr2 = 1'b0; m_df2 = 1'b0; m_oe2 = 1'b0;
    end
    last_acc8 = acc8;
    #1;
    check_all();
    $display("cyc=%0d v8=%b d8=%h acc8=%b dr8=%b df8=%b oe8=%b rdy8=%b | v2=%b d2=%b dr2=%b df2=%b oe2=%b",
             cyc, v8, d8, acc8, dr8, df8, oe8, in_ready8, v2, d2, dr2, df2, oe2);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 2'b00);
  endtask

  task automatic async_reset();
    #3 ALn = 1'b0;
    model_reset();
    #1;
    chk("arst_oe",    {1'b0, oe8},       2'b00);
    chk("arst_drdf",  {dr8, df8},        2'b00);
    chk("arst_ready", {1'b0, in_ready8}, 2'b01);
    chk("arst_busy",  {1'b0, busy8},     2'b00);
    chk("arst_oe2",   {1'b0, oe2},       2'b00);
    @(posedge CLK);
    #2 ALn = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_b4 [4];
    logic [1:0] exp_w2 [3];
    logic [1:0] w2_data [3];
    int guard;
    exp_b4  = '{2'b00, 2'b10, 2'b11, 2'b01};
    exp_w2  = '{2'b10, 2'b01, 2'b11};
    w2_data = '{2'b01, 2'b10, 2'b11};

    // Reset state
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_drdf",  {dr8, df8},        2'b00);
    chk("rst_oe",    {1'b0, oe8},       2'b00);
    chk("rst_ready", {1'b0, in_ready8}, 2'b01);
    chk("rst_busy",  {1'b0, busy8},     2'b00);
    chk("rst_ready2", {1'b0, in_ready2}, 2'b01);
    #2 ALn = 1'b1;

    // Single word 8'hB4 on W8, and the WIDTH=2 stream on W2 in parallel
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b1, 8'hB4, 1'b1, w2_data[0]);
      else if (i < 3) step(1'b0, 8'h00, 1'b1, w2_data[i]);
      else step(1'b0, 8'h00, 1'b0, 2'b00);
      chk("b4_beat", {dr8, df8}, exp_b4[i]);
      chk("b4_oe", {1'b0, oe8}, 2'b01);
      if (i < 3) begin
        chk("w2_beat", {dr2, df2}, exp_w2[i]);
        chk("w2_rdy_const", {1'b0, in_ready2}, 2'b01);
      end else begin
        chk("w2_oe_drop", {1'b0, oe2}, 2'b00);
      end
    end
    step(1'b0, 8'h00, 1'b0, 2'b00);
    chk("b4_hold1", {oe8, dr8 | df8}, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b00);
    chk("b4_hold2", {oe8, dr8 | df8}, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b00);
    chk("b4_oe_off", {oe8, busy8}, 2'b00);
    idle_steps(2);

    // Back-to-back FF then 00
    step(1'b1, 8'hFF, 1'b0, 2'b00);
    step(1'b1, 8'h00, 1'b0, 2'b00);
    chk("b2b_ready_low", {1'b0, in_ready8}, 2'b00);
    idle_steps(2);
    chk("b2b_ready_still_low", {1'b0, in_ready8}, 2'b00);
    step(1'b0, 8'h00, 1'b0, 2'b00);
    chk("b2b_word2_beat0", {dr8, df8, in_ready8}, 3'b001);
    idle_steps(8);

    // Backpressure 01, 02, 03
    step(1'b1, 8'h01, 1'b0, 2'b00);
    step(1'b1, 8'h02, 1'b0, 2'b00);
    guard = 0;
    do begin
      step(1'b1, 8'h03, 1'b0, 2'b00);
      guard++;
    end while (!last_acc8 && guard < 20);
    chk("bp_accept_bound", {1'b0, last_acc8}, 2'b01);
    idle_steps(12);

    // New word during HOLD
    step(1'b1, 8'hAA, 1'b0, 2'b00);
    idle_steps(4);
    step(1'b1, 8'h55, 1'b0, 2'b00);
    chk("hold_55_beat0", {oe8, dr8, df8}, 3'b110);
    idle_steps(8);

    // Asynchronous reset mid-word
    step(1'b1, 8'hF0, 1'b0, 2'b00);
    step(1'b0, 8'h00, 1'b0, 2'b00);
    async_reset();
    step(1'b1, 8'h0D, 1'b0, 2'b00);
    chk("arst_restart_beat0", {dr8, df8}, 2'b10);
    idle_steps(8);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 2'($urandom));
    end
    idle_steps(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_out_serializer.md
Name: ddr_out_serializer

Overview:
- Transmit-side counterpart to the pad input path: takes parallel words over a valid/ready handshake and serializes them two bits per clock onto a DDR output pair.
- dr is the rising-edge bit and df the falling-edge bit; they drive the output DDR register feeding OUTBUF/TRIBUFF.
- oe drives the TRIBUFF E pin, with a programmable turnaround hold after the last word.
- Sits between fabric logic and the IO cells of an SF2 output/bidirectional pad.

Parameters:
- WIDTH, 8, word width in bits; even, ≥2; one word takes WIDTH/2 beats.
- OE_HOLD, 2, cycles oe stays high after the last beat with no new word; 0 means oe drops immediately.
- IDLE_VAL, 1'b0, value driven on dr/df when no data beat is presented.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- ALn  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH  word to transmit, LSB first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word; equals !buf_full.
- dr  output  1  rising-edge data bit of the current beat (registered).
- df  output  1  falling-edge data bit of the current beat (registered).
- oe  output  1  pad output enable (registered).
- busy  output  1  (state != IDLE) | buf_full.

Behaviour:
- Reset (ALn low, asynchronous, effective immediately, mid-word included):
  - state=IDLE, cnt=0, hcnt=0, buf_full=0, sr=0.
  - dr=df=IDLE_VAL, oe=0; in_ready=1, busy=0.
  - A partially sent word is dropped.
- Internal storage:
  - shift register sr for the word in flight.
  - one-entry holding buffer buf with flag buf_full.
  - beat counter cnt, 0..WIDTH/2-1, where LAST=WIDTH/2-1.
  - hold counter hcnt, 0..OE_HOLD.
- Accept: occurs when in_valid & in_ready at a posedge.
- Beat k presents dr=word[2k], df=word[2k+1].
- States IDLE, SHIFT, HOLD. Transitions at each posedge:
  - IDLE
    - On accept: present beat 0 of in_data (zero-latency direct path), oe=1, cnt=0, go to SHIFT.
    - Otherwise: outputs stay at reset values.
  - SHIFT, cnt<LAST
    - Present beat cnt+1, cnt++, oe=1.
    - An accept in this cycle writes buf, buf_full=1.
  - SHIFT, cnt==LAST, priority order:
    - (a) buf_full: present beat 0 of buf, buf_full=0, cnt=0, stay in SHIFT.
    - (b) accept (buf empty): present beat 0 of in_data, cnt=0, stay in SHIFT.
    - (c) OE_HOLD>0: dr=df=IDLE_VAL, oe=1, hcnt=1, go to HOLD.
    - (d) otherwise: dr=df=IDLE_VAL, oe=0, go to IDLE.
  - HOLD
    - On accept: present beat 0 of in_data, oe=1, cnt=0, go to SHIFT; oe never deasserts.
    - Else if hcnt==OE_HOLD: oe=0, go to IDLE.
    - Else: hcnt++, oe=1, dr=df=IDLE_VAL.
- Throughput:
  - Back-to-back words produce gapless beats; no bubble between the last beat of word N and beat 0 of word N+1.
  - With buf full, in_ready=0 until the edge that moves buf into sr.
- WIDTH=2: every beat is LAST, so each word uses only the direct path or buf; full rate (one word per cycle) is sustained.
- No accept is possible while buf_full. in_data is sampled only on accept; it is don't-care otherwise.

Test Plan:
- Reset, then single word: WIDTH=8, OE_HOLD=2, accept 8'hB4 at edge 0.
  - Required: (dr,df) after edges 0..3 = (0,0),(1,0),(1,1),(0,1), oe=1.
  - Edges 4-5: dr=df=0, oe=1. Edge 6: oe=0, busy=0.
- Back-to-back: hold in_valid with 8'hFF then 8'h00.
  - Required: 8 consecutive beats (1,1)x4 then (0,0)x4 with no gap.
  - in_ready low from edge 1 until edge 4.
- Backpressure: offer 8'h01, 8'h02, 8'h03 continuously.
  - Required: third word held with in_ready=0 until edge 4.
  - First beat of 8'h03 appears after edge 8.
  - No word lost or duplicated.
- New word during HOLD: send 8'hAA, then accept 8'h55 on the first HOLD edge.
  - Required: oe stays 1 throughout.
  - 8'h55 beats (1,0)x4 start on that edge.
- Asynchronous reset mid-word: drop ALn after beat 1 of 8'hF0.
  - Required: oe=0, dr=df=0, in_ready=1 immediately, without waiting for CLK.
  - After ALn is released, the next word starts from beat 0.
- WIDTH=2, OE_HOLD=0, stream 2'b01, 2'b10, 2'b11 on consecutive edges.
  - Required: (1,0),(0,1),(1,1) on consecutive cycles, in_ready constantly 1.
  - oe=0 on the edge after the last word.
